// File: rtl/pwm_prescaler.sv
// Prescaler for pwm_core: clamps the divide value to a safe minimum and emits
// a one-cycle tick every eff_pscr enabled clocks.
`ifndef PWM_PSCR_WIDTH
  `define PWM_PSCR_WIDTH 16
`endif
`ifndef PWM_PSCR_MIN_VAL
  `define PWM_PSCR_MIN_VAL 2
`endif

module pwm_prescaler (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       en_i,
  input  logic [`PWM_PSCR_WIDTH-1:0] pscr_i,
  output logic                       tick_o
);

  localparam int PW = `PWM_PSCR_WIDTH;
  localparam logic [PW-1:0] PSCR_MIN = PW'(`PWM_PSCR_MIN_VAL);

  logic [PW-1:0] psc_q;
  logic [PW-1:0] eff_pscr;

  always_comb begin
    eff_pscr = (pscr_i < PSCR_MIN) ? PSCR_MIN : pscr_i;
    // >= so that shrinking pscr_i below the running count ends the interval
    // on the next cycle instead of wrapping through the full counter range.
    tick_o = en_i && (psc_q >= (eff_pscr - PW'(1)));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      psc_q <= '0;
    end else if (!en_i || tick_o) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_q + PW'(1);
    end
  end

endmodule

// File: rtl/pwm_core.sv
// Timebase and compare engine of the 4-channel PWM: prescaled up-counter that
// wraps at CMP, edge-aligned outputs, overflow flag and IRQ. PWM_SHADOW_EN
// enables period-boundary shadowing of CMP and CR0-3.
`ifndef PWM_CNT_WIDTH
  `define PWM_CNT_WIDTH 16
`endif
`ifndef PWM_CMP_WIDTH
  `define PWM_CMP_WIDTH 16
`endif
`ifndef PWM_CRX_WIDTH
  `define PWM_CRX_WIDTH 16
`endif
`ifndef PWM_PSCR_WIDTH
  `define PWM_PSCR_WIDTH 16
`endif

module pwm_core #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = `PWM_CNT_WIDTH
) (
  input  logic                                    clk_i,
  input  logic                                    rst_n_i,
  input  logic                                    en_i,
  input  logic                                    ovie_i,
  input  logic [`PWM_PSCR_WIDTH-1:0]              pscr_i,
  input  logic [`PWM_CMP_WIDTH-1:0]               cmp_i,
  input  logic [CH_NUM-1:0][`PWM_CRX_WIDTH-1:0]   cr_i,
  input  logic                                    ovif_clr_i,
  output logic [CNT_W-1:0]                        cnt_o,
  output logic                                    ovif_o,
  output logic [CH_NUM-1:0]                       pwm_o,
  output logic                                    irq_o
);

  logic                                  tick;
  logic                                  overflow;
  logic                                  ovif_next;
  logic [CNT_W-1:0]                      cnt_q;
  logic                                  ovif_q;
  logic                                  irq_q;
  logic [CH_NUM-1:0]                     pwm_q;
  logic [CH_NUM-1:0]                     pwm_d;
  logic [`PWM_CMP_WIDTH-1:0]             cmp_eff;
  logic [CH_NUM-1:0][`PWM_CRX_WIDTH-1:0] cr_eff;

  pwm_prescaler u_prescaler (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (en_i),
    .pscr_i  (pscr_i),
    .tick_o  (tick)
  );

  always_comb begin
    overflow  = tick && (cnt_q >= cmp_eff);
    ovif_next = overflow || (ovif_q && !ovif_clr_i);
    pwm_d     = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      pwm_d[i] = en_i && (cnt_q < cr_eff[i]);
    end
  end

`ifdef PWM_SHADOW_EN
  logic [`PWM_CMP_WIDTH-1:0]             cmp_sh;
  logic [CH_NUM-1:0][`PWM_CRX_WIDTH-1:0] cr_sh;

  // Reload while idle too, so the first period after enable uses fresh values.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cmp_sh <= '0;
      cr_sh  <= '0;
    end else if (overflow || !en_i) begin
      cmp_sh <= cmp_i;
      cr_sh  <= cr_i;
    end
  end

  assign cmp_eff = cmp_sh;
  assign cr_eff  = cr_sh;
`else
  assign cmp_eff = cmp_i;
  assign cr_eff  = cr_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      ovif_q <= 1'b0;
      irq_q  <= 1'b0;
      pwm_q  <= '0;
    end else begin
      if (!en_i) begin
        cnt_q <= '0;
      end else if (tick) begin
        cnt_q <= overflow ? '0 : cnt_q + CNT_W'(1);
      end
      ovif_q <= ovif_next;
      irq_q  <= ovif_next && ovie_i;
      pwm_q  <= pwm_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign ovif_o = ovif_q;
  assign pwm_o  = pwm_q;
  assign irq_o  = irq_q;

endmodule

// File: tb/tb_pwm_core.sv
// Directed bench for pwm_core: a per-cycle vector table for the basic waveform
// plus hand-written sequences for clamp, flag race, disable, reset, shadow, shrink.
module tb_pwm_core;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             ovie;
  logic [15:0]      pscr;
  logic [15:0]      cmp;
  logic [3:0][15:0] cr;
  logic             ovif_clr;
  logic [15:0]      cnt;
  logic             ovif;
  logic [3:0]       pwm;
  logic             irq;

  int n_vec  = 0;
  int n_miss = 0;

  pwm_core dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .en_i       (en),
    .ovie_i     (ovie),
    .pscr_i     (pscr),
    .cmp_i      (cmp),
    .cr_i       (cr),
    .ovif_clr_i (ovif_clr),
    .cnt_o      (cnt),
    .ovif_o     (ovif),
    .pwm_o      (pwm),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic        clr;
    logic [15:0] exp_cnt;
    logic [3:0]  exp_pwm;
    logic        exp_ovif;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string name, input logic [15:0] c, input logic [3:0] p,
                           input logic o, input logic i);
    check({name, ".cnt"}, cnt, c);
    check({name, ".pwm"}, {12'b0, pwm}, {12'b0, p});
    check({name, ".ovif"}, {15'b0, ovif}, {15'b0, o});
    check({name, ".irq"}, {15'b0, irq}, {15'b0, i});
  endtask

  // Reset, then one idle edge with en=0 so the configuration is taken up.
  task automatic do_reset();
    rst_n    = 1'b0;
    en       = 1'b0;
    ovif_clr = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; ovie = 1'b0; pscr = '0; cmp = '0; cr = '0; ovif_clr = 1'b0;
    @(negedge clk);

    // Basic waveform: pscr=2, cmp=3, cr0=2 cr1=0 cr2=4 cr3=1; rows are edges 1..10.
    vecs[0] = '{1'b1, 1'b0, 16'd0, 4'b1101, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'd1, 4'b1101, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'd1, 4'b0101, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'd2, 4'b0101, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'd2, 4'b0100, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'd3, 4'b0100, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 16'd3, 4'b0100, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 16'd0, 4'b0100, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 16'd0, 4'b1101, 1'b1, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 16'd1, 4'b1101, 1'b1, 1'b1};

    pscr = 16'd2; cmp = 16'd3; ovie = 1'b1;
    cr[0] = 16'd2; cr[1] = 16'd0; cr[2] = 16'd4; cr[3] = 16'd1;
    do_reset();
    check_all("reset", 16'd0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      en       = vecs[i].en;
      ovif_clr = vecs[i].clr;
      step(1);
      check_all($sformatf("basic[%0d]", i), vecs[i].exp_cnt, vecs[i].exp_pwm,
                vecs[i].exp_ovif, vecs[i].exp_irq);
    end

    // Clamp pscr=0, then clear on a quiet cycle, then clear racing an overflow.
    pscr = 16'd0; cmp = 16'd0; cr = '0; ovie = 1'b1;
    do_reset();
    en = 1'b1;
    step(1); check_all("clamp0.e1", 16'd0, 4'b0000, 1'b0, 1'b0);
    step(1); check_all("clamp0.e2", 16'd0, 4'b0000, 1'b1, 1'b1);
    ovif_clr = 1'b1;
    step(1); check_all("clr_quiet", 16'd0, 4'b0000, 1'b0, 1'b0);
    ovif_clr = 1'b0;
    step(1); check_all("reset_ovf", 16'd0, 4'b0000, 1'b1, 1'b1);
    step(1); check_all("hold", 16'd0, 4'b0000, 1'b1, 1'b1);
    ovif_clr = 1'b1;
    step(1); check_all("clr_race", 16'd0, 4'b0000, 1'b1, 1'b1);
    ovif_clr = 1'b0;

    // Clamp pscr=1 with the interrupt masked.
    pscr = 16'd1; ovie = 1'b0;
    do_reset();
    en = 1'b1;
    step(1); check_all("clamp1.e1", 16'd0, 4'b0000, 1'b0, 1'b0);
    step(1); check_all("clamp1.e2", 16'd0, 4'b0000, 1'b1, 1'b0);

    // Disable at cnt=5 after one overflow, then a one-cycle reset mid-count.
    pscr = 16'd2; cmp = 16'd9; ovie = 1'b1;
    cr[0] = 16'd7; cr[1] = 16'd7; cr[2] = 16'd7; cr[3] = 16'd7;
    do_reset();
    en = 1'b1;
    step(31); check_all("pre_dis", 16'd5, 4'b1111, 1'b1, 1'b1);
    en = 1'b0;
    step(1); check_all("disable", 16'd0, 4'b0000, 1'b1, 1'b1);
    en = 1'b1;
    step(5); check_all("reen", 16'd2, 4'b1111, 1'b1, 1'b1);
    rst_n = 1'b0;
    step(1); check_all("mid_rst", 16'd0, 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Duty change mid-period: cr0 5 -> 2 written at cnt=3.
    pscr = 16'd2; cmp = 16'd9; ovie = 1'b0;
    cr[0] = 16'd5; cr[1] = 16'd0; cr[2] = 16'd0; cr[3] = 16'd0;
    do_reset();
    en = 1'b1;
    step(6); check("sh.cnt3", cnt, 16'd3);
    cr[0] = 16'd2;
`ifdef PWM_SHADOW_EN
    step(2);  check("sh.e8",  {15'b0, pwm[0]}, 16'd1);
    step(2);  check("sh.e10", {15'b0, pwm[0]}, 16'd1);
`else
    step(2);  check("sh.e8",  {15'b0, pwm[0]}, 16'd0);
    step(2);  check("sh.e10", {15'b0, pwm[0]}, 16'd0);
`endif
    step(1);  check("sh.e11", {15'b0, pwm[0]}, 16'd0);
    step(10); check("sh.e21", {15'b0, pwm[0]}, 16'd1);
    step(3);  check("sh.e24", {15'b0, pwm[0]}, 16'd1);
    step(1);  check("sh.e25", {15'b0, pwm[0]}, 16'd0);

    // Prescaler shrink from 100 to 10 with psc_q at 50.
    pscr = 16'd100; cmp = 16'd100; cr = '0;
    do_reset();
    en = 1'b1;
    step(50); check("shrink.pre", cnt, 16'd0);
    pscr = 16'd10;
    step(1);  check("shrink.tick", cnt, 16'd1);
    step(9);  check("shrink.wait", cnt, 16'd1);
    step(1);  check("shrink.t2", cnt, 16'd2);
    step(10); check("shrink.t3", cnt, 16'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
